flip_alpha_gen: RTL and testbench

FLIP_ALPHA_GEN -- requirements
Module: flip_alpha_gen

---
 rtl/flip_alpha_gen_if.sv | 42 ++++
 rtl/flip_alpha_gen.sv | 146 ++++++++++++++
 tb/tb_flip_alpha_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/flip_alpha_gen_if.sv
// flip_alpha_gen_if: sample stream, alpha result and handshake bundle for flip_alpha_gen.
// Ports: i_code (field select), i_rel_valid/i_rel/i_rel_last/o_rel_ready (sample stream),
// o_flip_alpha_S{1,3,5,7}_{1,2} (alpha powers of the two weakest positions),
// o_flip_alpha_valid/i_flip_ack (result handshake), o_len_err (frame length violation),
// o_pos_1/o_pos_2 (selected positions, only when FLIP_ALPHA_POS_OUT_EN is defined).
interface flip_alpha_if;
    logic [1:0] i_code;
    logic       i_rel_valid;
    logic [6:0] i_rel;
    logic       i_rel_last;
    logic       o_rel_ready;
    logic [9:0] o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1;
    logic [9:0] o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2;
    logic       o_flip_alpha_valid;
    logic       i_flip_ack;
    logic       o_len_err;
`ifdef FLIP_ALPHA_POS_OUT_EN
    logic [9:0] o_pos_1, o_pos_2;
`endif
    modport master (
        output i_code, i_rel_valid, i_rel, i_rel_last, i_flip_ack,
        input  o_rel_ready, o_flip_alpha_valid,
        input  o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1,
        input  o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2,
`ifdef FLIP_ALPHA_POS_OUT_EN
        input  o_len_err, o_pos_1, o_pos_2
`else
        input  o_len_err
`endif
    );
    modport slave (
        input  i_code, i_rel_valid, i_rel, i_rel_last, i_flip_ack,
        output o_rel_ready, o_flip_alpha_valid,
        output o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1,
        output o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2,
`ifdef FLIP_ALPHA_POS_OUT_EN
        output o_len_err, o_pos_1, o_pos_2
`else
        output o_len_err
`endif
    );
endinterface

// File: rtl/flip_alpha_gen.sv
// flip_alpha_gen: finds the two least reliable positions of a frame and emits alpha^(k*p), k=1,3,5,7.
// Ports: i_clk (clock), i_rst_n (async active-low reset), bus (flip_alpha_if.slave: sample
// stream in, alpha powers / valid / len_err out, ack in). Macro FLIP_ALPHA_POS_OUT_EN adds
// o_pos_1/o_pos_2 on the interface carrying the selected positions.
module flip_alpha_gen (
    input  logic        i_clk,
    input  logic        i_rst_n,
    flip_alpha_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SCAN, POW, ODD, HOLD} state_t;
    state_t state, state_nx;
    logic [1:0] code_q, code_in;
    logic [6:0] min1, min2, b_min1, b_min2, n_min1, n_min2;
    logic [9:0] pos1, pos2, idx, b_pos1, b_pos2, b_idx, n_pos1, n_pos2;
    logic       full, len_err, valid, accept, take, first, lt1, lt2;
    logic [3:0] cnt;
    logic [9:0] a1, a1_3, a1_5, a1_7, a2, a2_3, a2_5, a2_7, sq1, sq2;

    // multiply by alpha (x) modulo the field polynomial; code 0/1/2 = GF(2^6)/(2^8)/(2^10)
    function automatic logic [9:0] xt(input logic [9:0] r, input logic [1:0] c);
        logic top;
        top = c == 2'd0 ? r[5] : c == 2'd1 ? r[7] : r[9];
        return {r[8:0], 1'b0} ^ (top ? (c == 2'd0 ? 10'h043 : c == 2'd1 ? 10'h11d : 10'h009) : 10'h000);
    endfunction

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b, input logic [1:0] c);
        logic [9:0] r;
        r = '0;
        for (int i = 9; i >= 0; i--) r = xt(r, c) ^ (b[i] ? a : 10'd0);
        return r;
    endfunction

    assign bus.o_rel_ready = state == IDLE || state == SCAN;
    assign accept  = bus.i_rel_valid && bus.o_rel_ready;
    assign code_in = bus.i_code == 2'b11 ? 2'b10 : bus.i_code;
    assign sq1 = gf_mul(a1, a1, code_q);
    assign sq2 = gf_mul(a2, a2, code_q);

    // a frame's first sample compares against fresh minima and starts at index n-1
    always_comb begin
        first  = state == IDLE;
        b_min1 = first ? 7'h7f : min1;
        b_min2 = first ? 7'h7f : min2;
        b_pos1 = first ? 10'd0 : pos1;
        b_pos2 = first ? 10'd0 : pos2;
        b_idx  = first ? (code_in == 2'd0 ? 10'd62 : code_in == 2'd1 ? 10'd254 : 10'd1022) : idx;
        take   = accept && (first || !full);
        lt1    = bus.i_rel < b_min1;
        lt2    = bus.i_rel < b_min2;
        n_min1 = lt1 ? bus.i_rel : b_min1;
        n_pos1 = lt1 ? b_idx : b_pos1;
        n_min2 = lt1 ? b_min1 : lt2 ? bus.i_rel : b_min2;
        n_pos2 = lt1 ? b_pos1 : lt2 ? b_idx : b_pos2;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bus.i_rel_last ? POW : SCAN;
            SCAN:    if (accept && bus.i_rel_last) state_nx = POW;
            POW:     if (cnt == 4'd9) state_nx = ODD;
            ODD:     if (cnt == 4'd2) state_nx = HOLD;
            HOLD:    if (bus.i_flip_ack && valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q  <= '0;
            min1    <= 7'h7f;
            min2    <= 7'h7f;
            pos1    <= '0;
            pos2    <= '0;
            idx     <= '0;
            full    <= 1'b0;
            len_err <= 1'b0;
            valid   <= 1'b0;
            cnt     <= '0;
            a1      <= '0;
            a1_3    <= '0;
            a1_5    <= '0;
            a1_7    <= '0;
            a2      <= '0;
            a2_3    <= '0;
            a2_5    <= '0;
            a2_7    <= '0;
        end else begin
            if (accept && first) begin
                code_q  <= code_in;
                len_err <= bus.i_rel_last;
            end
            if (accept && !first && full) len_err <= 1'b1;
            if (take) begin
                min1 <= n_min1;
                min2 <= n_min2;
                pos1 <= n_pos1;
                pos2 <= n_pos2;
                idx  <= b_idx == 10'd0 ? 10'd0 : b_idx - 10'd1;
                full <= b_idx == 10'd0;
            end
            if (accept && bus.i_rel_last) begin
                cnt <= '0;
                a1  <= 10'd1;
                a2  <= 10'd1;
            end
            // MSB-first square-and-multiply over the 10 position bits
            if (state == POW) begin
                cnt <= cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
                a1  <= pos1[4'd9 - cnt] ? xt(sq1, code_q) : sq1;
                a2  <= pos2[4'd9 - cnt] ? xt(sq2, code_q) : sq2;
            end
            if (state == ODD) begin
                cnt  <= cnt == 4'd2 ? 4'd0 : cnt + 4'd1;
                a1_3 <= cnt == 4'd0 ? gf_mul(a1, sq1, code_q) : a1_3;
                a2_3 <= cnt == 4'd0 ? gf_mul(a2, sq2, code_q) : a2_3;
                a1_5 <= cnt == 4'd1 ? gf_mul(a1_3, sq1, code_q) : a1_5;
                a2_5 <= cnt == 4'd1 ? gf_mul(a2_3, sq2, code_q) : a2_5;
                a1_7 <= cnt == 4'd2 ? gf_mul(a1_5, sq1, code_q) : a1_7;
                a2_7 <= cnt == 4'd2 ? gf_mul(a2_5, sq2, code_q) : a2_7;
            end
            // valid follows HOLD entry by one edge so results are settled before release
            valid <= state == HOLD && state_nx == HOLD;
        end
    end

    assign bus.o_flip_alpha_valid = valid;
    assign bus.o_len_err          = len_err;
    assign bus.o_flip_alpha_S1_1  = a1;
    assign bus.o_flip_alpha_S3_1  = a1_3;
    assign bus.o_flip_alpha_S5_1  = code_q == 2'b10 ? a1_5 : 10'd0;
    assign bus.o_flip_alpha_S7_1  = code_q == 2'b10 ? a1_7 : 10'd0;
    assign bus.o_flip_alpha_S1_2  = a2;
    assign bus.o_flip_alpha_S3_2  = a2_3;
    assign bus.o_flip_alpha_S5_2  = code_q == 2'b10 ? a2_5 : 10'd0;
    assign bus.o_flip_alpha_S7_2  = code_q == 2'b10 ? a2_7 : 10'd0;
`ifdef FLIP_ALPHA_POS_OUT_EN
    assign bus.o_pos_1 = pos1;
    assign bus.o_pos_2 = pos2;
`endif
endmodule

// File: tb/tb_flip_alpha_gen.sv
// tb_flip_alpha_gen: scoreboard bench for flip_alpha_gen; expectations queued per frame, popped on valid.
module tb_flip_alpha_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flip_alpha_if bus();
    flip_alpha_gen dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [7:0][9:0] s;
        logic            err;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_e;
    logic [6:0] rel_arr [1024];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nlen(input logic [1:0] c);
        return c == 2'd0 ? 63 : c == 2'd1 ? 255 : 1023;
    endfunction

    function automatic logic [9:0] mulx(input logic [9:0] v, input logic [1:0] c);
        logic [10:0] t;
        int m;
        t = {v, 1'b0};
        m = c == 2'd0 ? 6 : c == 2'd1 ? 8 : 10;
        if (t[m]) t = t ^ (c == 2'd0 ? 11'h043 : c == 2'd1 ? 11'h11d : 11'h409);
        return t[9:0];
    endfunction

    function automatic logic [9:0] apow(input int e, input logic [1:0] c);
        logic [9:0] v;
        v = 10'd1;
        for (int i = 0; i < e; i++) v = mulx(v, c);
        return v;
    endfunction

    function automatic logic [9:0] dut_s(input int j);
        case (j)
            0:       return bus.o_flip_alpha_S1_1;
            1:       return bus.o_flip_alpha_S3_1;
            2:       return bus.o_flip_alpha_S5_1;
            3:       return bus.o_flip_alpha_S7_1;
            4:       return bus.o_flip_alpha_S1_2;
            5:       return bus.o_flip_alpha_S3_2;
            6:       return bus.o_flip_alpha_S5_2;
            default: return bus.o_flip_alpha_S7_2;
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] c, input int len);
        int   n, m1, m2, p1, p2, r;
        exp_t e;
        n = nlen(c);
        m1 = 127; m2 = 127; p1 = 0; p2 = 0;
        for (int i = 0; i < len && i < n; i++) begin
            r = int'(rel_arr[i]);
            if (r < m1) begin
                m2 = m1; p2 = p1; m1 = r; p1 = n - 1 - i;
            end else if (r < m2) begin
                m2 = r; p2 = n - 1 - i;
            end
        end
        e.err = len < 2 || len > n;
        for (int k = 0; k < 4; k++) begin
            e.s[k]     = apow(((2 * k + 1) * p1) % n, c);
            e.s[4 + k] = apow(((2 * k + 1) * p2) % n, c);
        end
        if (c < 2'd2) begin
            e.s[2] = '0; e.s[3] = '0; e.s[6] = '0; e.s[7] = '0;
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] c, input int len);
        push_exp(c, len);
        bus.i_code = c;
        for (int i = 0; i < len; i++) begin
            bus.i_rel_valid = 1'b1;
            bus.i_rel       = rel_arr[i];
            bus.i_rel_last  = i == len - 1;
            @(negedge clk);
        end
        bus.i_rel_valid = 1'b0;
        bus.i_rel_last  = 1'b0;
    endtask

    task automatic collect();
        int cyc;
        cyc = 0;
        while (!bus.o_flip_alpha_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'd14);
        check("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            last_e = sb.pop_front();
            for (int j = 0; j < 8; j++) check($sformatf("alpha%0d", j), 32'(dut_s(j)), 32'(last_e.s[j]));
            check("len_err", 32'(bus.o_len_err), 32'(last_e.err));
        end
    endtask

    task automatic ack();
        bus.i_flip_ack = 1'b1;
        @(negedge clk);
        bus.i_flip_ack = 1'b0;
        check("ready_after_ack", 32'(bus.o_rel_ready), 32'd1);
        check("valid_after_ack", 32'(bus.o_flip_alpha_valid), 32'd0);
    endtask

    task automatic fill(input int len, input int hi);
        for (int i = 0; i < len; i++) rel_arr[i] = 7'($urandom_range(0, hi));
    endtask

    initial begin
        logic [1:0] c;
        int len;
        bus.i_code = '0; bus.i_rel_valid = 1'b0; bus.i_rel = '0; bus.i_rel_last = 1'b0; bus.i_flip_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.o_rel_ready), 32'd1);
        check("rst_valid", 32'(bus.o_flip_alpha_valid), 32'd0);
        check("rst_s1_1", 32'(bus.o_flip_alpha_S1_1), 32'd0);
        check("rst_len_err", 32'(bus.o_len_err), 32'd0);
        rst_n = 1'b1;
        // full GF(2^10) frame, weakest at index 1 then index 0
        for (int i = 0; i < 1023; i++) rel_arr[i] = 7'h40;
        rel_arr[1021] = 7'd3;
        rel_arr[1022] = 7'd5;
        send(2'b10, 1023);
        collect();
        check("r24_s1_1", 32'(bus.o_flip_alpha_S1_1), 32'h002);
        check("r24_s7_1", 32'(bus.o_flip_alpha_S7_1), 32'h080);
        check("r24_s5_2", 32'(bus.o_flip_alpha_S5_2), 32'h001);
        ack();
        // GF(2^6) tie between index 9 (earlier) and index 5
        for (int i = 0; i < 63; i++) rel_arr[i] = 7'h30;
        rel_arr[53] = 7'd2;
        rel_arr[57] = 7'd2;
        send(2'b00, 63);
        collect();
        check("r25_s5_1", 32'(bus.o_flip_alpha_S5_1), 32'd0);
        check("r25_s7_2", 32'(bus.o_flip_alpha_S7_2), 32'd0);
        ack();
        // GF(2^8) overlong frame: trailing zero-reliability samples must be ignored
        for (int i = 0; i < 256; i++) rel_arr[i] = 7'($urandom_range(10, 127));
        for (int i = 256; i < 300; i++) rel_arr[i] = 7'd0;
        send(2'b01, 300);
        collect();
        check("r26_len_err", 32'(bus.o_len_err), 32'd1);
        ack();
        // single-sample frame
        rel_arr[0] = 7'd9;
        send(2'b10, 1);
        collect();
        check("r27_s1_2", 32'(bus.o_flip_alpha_S1_2), 32'h001);
        ack();
        // reset in the middle of POW, then a frame starting on the first edge after release
        fill(20, 127);
        send(2'b10, 20);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstpow_s1_1", 32'(bus.o_flip_alpha_S1_1), 32'd0);
        check("rstpow_s1_2", 32'(bus.o_flip_alpha_S1_2), 32'd0);
        check("rstpow_valid", 32'(bus.o_flip_alpha_valid), 32'd0);
        sb.delete(sb.size() - 1);
        @(negedge clk);
        check("rstpow_ready", 32'(bus.o_rel_ready), 32'd1);
        rst_n = 1'b1;
        fill(50, 127);
        send(2'b10, 50);
        collect();
        ack();
        // HOLD must ignore samples and wait for ack
        fill(100, 30);
        send(2'b01, 100);
        collect();
        bus.i_rel_valid = 1'b1;
        bus.i_rel = 7'd0;
        bus.i_rel_last = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_valid", 32'(bus.o_flip_alpha_valid), 32'd1);
        check("hold_ready", 32'(bus.o_rel_ready), 32'd0);
        check("hold_s1_1", 32'(bus.o_flip_alpha_S1_1), 32'(last_e.s[0]));
        check("hold_s3_2", 32'(bus.o_flip_alpha_S3_2), 32'(last_e.s[5]));
        bus.i_rel_valid = 1'b0;
        bus.i_rel_last = 1'b0;
        ack();
        // random frames over all codes, including reserved 11
        for (int t = 0; t < 6; t++) begin
            c = 2'($urandom_range(0, 3));
            len = $urandom_range(2, nlen(c));
            fill(len, t < 3 ? 15 : 127);
            send(c, len);
            collect();
            ack();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
